// File: rtl/spi_master_if.sv
// Command/pin bundle of the SPI initiator: host side (start/tx_data/rx_data/busy/done) plus the SPI pins.
// The master modport is the initiator's view; slave is the view of whatever drives commands and miso.
interface spi_master_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  busy;
   logic                  done;
   logic                  sclk;
   logic                  ss;
   logic                  mosi;
   logic                  miso;

   modport master (
      input  start, tx_data, miso,
      output rx_data, busy, done, sclk, ss, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  rx_data, busy, done, sclk, ss, mosi
   );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first: done pulses (2*DATA_WIDTH+1)*CLK_DIV cycles after start is accepted.
// No backpressure: start is only sampled while idle; requests arriving while busy are dropped.
module spi_master #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4
) (
   input  logic         clk,
   input  logic         rst_L,
   spi_master_if.master bus
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DIV_W-1:0]      r_div;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_rx;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic                  r_sclk;
   logic                  r_ss;
   logic                  r_busy;
   logic                  r_done;

   logic w_div_end;
   logic w_accept;
   logic w_rise;
   logic w_fall;
   logic w_finish;
   logic w_sclk_nxt;
   logic w_ss_nxt;
   logic w_busy_nxt;
   logic w_done_nxt;

   assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_SETUP;
         S_SETUP: if (w_div_end) w_state_nxt = S_XFER;
         S_XFER:  if (w_div_end && r_sclk && (r_cnt == CNT_W'(DATA_WIDTH))) w_state_nxt = S_HOLD;
         S_HOLD:  if (w_div_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept   = 1'b0;
      w_rise     = 1'b0;
      w_fall     = 1'b0;
      w_finish   = 1'b0;
      w_sclk_nxt = r_sclk;
      w_ss_nxt   = r_ss;
      w_busy_nxt = r_busy;
      w_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: if (bus.start) begin
            w_accept   = 1'b1;
            w_ss_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
            w_sclk_nxt = 1'b0;
         end
         S_SETUP: if (w_div_end) begin
            w_rise     = 1'b1;
            w_sclk_nxt = 1'b1;
         end
         // Every divider wrap in XFER is an sclk edge; the last fall drops sclk into HOLD.
         S_XFER: if (w_div_end) begin
            w_rise     = ~r_sclk;
            w_fall     = r_sclk;
            w_sclk_nxt = ~r_sclk;
         end
         S_HOLD: if (w_div_end) begin
            w_finish   = 1'b1;
            w_ss_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_div     <= '0;
         r_cnt     <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_sclk    <= 1'b0;
         r_ss      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_sclk <= w_sclk_nxt;
         r_ss   <= w_ss_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (r_state == S_IDLE || w_div_end) r_div <= '0;
         else                                r_div <= r_div + 1'b1;
         if (w_accept) begin
            r_tx  <= bus.tx_data;
            r_rx  <= '0;
            r_cnt <= '0;
         end
         if (w_rise) begin
            r_rx  <= (r_rx << 1) | DATA_WIDTH'(bus.miso);
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_fall)   r_tx      <= r_tx << 1;
         if (w_finish) r_rx_data <= r_rx;
      end
   end

   assign bus.sclk    = r_sclk;
   assign bus.ss      = r_ss;
   assign bus.mosi    = r_tx[DATA_WIDTH-1];
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.rx_data = r_rx_data;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: one instance at CLK_DIV=4 and one at CLK_DIV=1, both 8-bit,
// with a slave model that shifts a word out on sclk falls or loops mosi back to miso.
module tb_spi_master;
   localparam int W  = 8;
   localparam int H0 = 4;
   localparam int H1 = 1;

   typedef struct {
      int           d;
      logic [W-1:0] tx;
      logic [W-1:0] rx;
      int           edge0;
   } exp_t;

   logic clk = 1'b0;
   logic rst_L;
   always #5 clk = ~clk;

   spi_master_if #(.DATA_WIDTH(W)) bus0 ();
   spi_master_if #(.DATA_WIDTH(W)) bus1 ();

   spi_master #(.DATA_WIDTH(W), .CLK_DIV(H0)) dut0 (.clk(clk), .rst_L(rst_L), .bus(bus0));
   spi_master #(.DATA_WIDTH(W), .CLK_DIV(H1)) dut1 (.clk(clk), .rst_L(rst_L), .bus(bus1));

   logic         drv_start [2];
   logic [W-1:0] drv_tx    [2];
   bit           lb        [2];
   logic         slv_miso  [2];
   logic [W-1:0] slv_word  [2];
   int           slv_idx   [2];

   assign bus0.start   = drv_start[0];
   assign bus0.tx_data = drv_tx[0];
   assign bus0.miso    = lb[0] ? bus0.mosi : slv_miso[0];
   assign bus1.start   = drv_start[1];
   assign bus1.tx_data = drv_tx[1];
   assign bus1.miso    = lb[1] ? bus1.mosi : slv_miso[1];

   logic [1:0]     w_sclk, w_ss, w_mosi, w_busy, w_done;
   logic [2*W-1:0] w_rx;
   assign w_sclk = {bus1.sclk, bus0.sclk};
   assign w_ss   = {bus1.ss,   bus0.ss};
   assign w_mosi = {bus1.mosi, bus0.mosi};
   assign w_busy = {bus1.busy, bus0.busy};
   assign w_done = {bus1.done, bus0.done};
   assign w_rx   = {bus1.rx_data, bus0.rx_data};

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   int           rise_cnt  [2];
   int           rise_bad  [2];
   int           ss_hi     [2];
   logic [W-1:0] mosi_bits [2];
   logic         prev_sclk [2];
   logic         prev_ss   [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int hdiv(input int d);
      return (d == 0) ? H0 : H1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      for (int d = 0; d < 2; d++) begin
         rise_cnt[d]  = 0;
         rise_bad[d]  = 0;
         ss_hi[d]     = 0;
         mosi_bits[d] = '0;
         prev_sclk[d] = 1'b0;
         prev_ss[d]   = 1'b0;
         slv_miso[d]  = 1'b0;
         slv_idx[d]   = -1;
      end
   endtask

   // Called on every falling clk edge, i.e. it sees what the next rising edge ("edge cyc+1") samples.
   task automatic mon(input int d, input logic sclk, input logic ss, input logic mosi,
                      input logic done, input logic busy, input logic [W-1:0] rx);
      int   edge_n;
      exp_t e;
      edge_n = cyc + 1;
      if (ss) ss_hi[d]++;
      if (sclk && !prev_sclk[d]) begin
         rise_cnt[d]++;
         mosi_bits[d] = {mosi_bits[d][W-2:0], mosi};
         if (exp_q.size() > 0 && edge_n != exp_q[0].edge0 + 1 + (2 * rise_cnt[d] - 1) * hdiv(d))
            rise_bad[d]++;
      end
      if (ss && !prev_ss[d]) begin
         slv_idx[d]  = W - 1;
         slv_miso[d] = slv_word[d][W-1];
      end else if (!sclk && prev_sclk[d]) begin
         slv_idx[d]--;
         slv_miso[d] = (slv_idx[d] >= 0) ? slv_word[d][slv_idx[d]] : 1'b0;
      end
      if (done) begin
         if (exp_q.size() == 0 || exp_q[0].d != d) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: dut%0d pulsed done with rx=0x%0h, want no done", d, rx);
         end else begin
            e = exp_q.pop_front();
            chk("done_edge",      edge_n,       e.edge0 + 1 + (2 * W + 1) * hdiv(d));
            chk("rx_data",        rx,           e.rx);
            chk("mosi_at_rises",  mosi_bits[d], e.tx);
            chk("sclk_rises",     rise_cnt[d],  W);
            chk("rise_edge_errs", rise_bad[d],  0);
            chk("ss_high_cycles", ss_hi[d],     (2 * W + 1) * hdiv(d));
            chk("busy_at_done",   busy,         0);
         end
         rise_cnt[d]  = 0;
         rise_bad[d]  = 0;
         ss_hi[d]     = 0;
         mosi_bits[d] = '0;
      end
      prev_sclk[d] = sclk;
      prev_ss[d]   = ss;
   endtask

   always @(negedge clk) begin
      mon(0, bus0.sclk, bus0.ss, bus0.mosi, bus0.done, bus0.busy, bus0.rx_data);
      mon(1, bus1.sclk, bus1.ss, bus1.mosi, bus1.done, bus1.busy, bus1.rx_data);
   end

   task automatic check_idle(input int d);
      chk("idle_sclk", w_sclk[d], 0);
      chk("idle_ss",   w_ss[d],   0);
      chk("idle_mosi", w_mosi[d], 0);
      chk("idle_busy", w_busy[d], 0);
      chk("idle_done", w_done[d], 0);
      chk("idle_rx",   w_rx[d*W +: W], 0);
   endtask

   // Entered just after a falling edge; the next rising edge accepts the request.
   task automatic launch(input int d, input logic [W-1:0] tx, input logic [W-1:0] sw, input bit loop);
      exp_t e;
      lb[d]        = loop;
      slv_word[d]  = sw;
      drv_tx[d]    = tx;
      drv_start[d] = 1'b1;
      e.d     = d;
      e.tx    = tx;
      e.rx    = loop ? tx : sw;
      e.edge0 = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      drv_start[d] = 1'b0;
      drv_tx[d]    = W'($urandom);
   endtask

   task automatic wait_idle(input int d);
      for (int i = 0; i < 400; i++) begin
         if (!w_busy[d]) return;
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: dut%0d busy=1 after 400 cycles, want 0", d);
   endtask

   task automatic wait_done(input int d);
      for (int i = 0; i < 400; i++) begin
         if (w_done[d]) return;
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL wait_done: dut%0d done=0 after 400 cycles, want 1", d);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) return;
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d transfers still pending, want 0", exp_q.size());
      exp_q.delete();
   endtask

   initial begin
      int edge0;
      rst_L = 1'b0;
      for (int d = 0; d < 2; d++) begin
         drv_start[d] = 1'b0;
         drv_tx[d]    = '0;
         lb[d]        = 1'b0;
         slv_word[d]  = '0;
      end
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle(0);
      check_idle(1);
      rst_L = 1'b1;
      @(negedge clk);

      // Nominal transfer with a second request at edge 20 that must be dropped.
      launch(0, 8'hA5, 8'h3C, 1'b0);
      edge0 = cyc;
      while (cyc + 1 < edge0 + 20) @(negedge clk);
      drv_start[0] = 1'b1;
      drv_tx[0]    = 8'hFF;
      @(negedge clk);
      drv_start[0] = 1'b0;
      wait_drain();
      repeat (80) @(negedge clk);
      chk("busy_after_ignored_start", w_busy[0], 0);

      // Back-to-back: second start held in the done cycle.
      launch(0, 8'h81, 8'h00, 1'b1);
      wait_done(0);
      chk("ss_low_in_done_cycle", w_ss[0], 0);
      launch(0, 8'h7E, 8'h00, 1'b1);
      chk("ss_high_after_one_gap", w_ss[0], 1);
      wait_drain();

      // Asynchronous reset after the 4th sclk rise, mid-cycle.
      launch(0, 8'hA5, 8'h00, 1'b1);
      for (int i = 0; i < 200 && rise_cnt[0] < 4; i++) @(negedge clk);
      chk("rises_before_reset", rise_cnt[0], 4);
      @(posedge clk);
      #2 rst_L = 1'b0;
      #1;
      check_idle(0);
      clear_model();
      @(posedge clk);
      @(negedge clk);
      rst_L = 1'b1;
      @(negedge clk);
      launch(0, 8'hC3, 8'h00, 1'b1);
      wait_drain();

      // Fastest divider.
      launch(1, 8'h5A, 8'h00, 1'b1);
      wait_drain();

      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 12; n++) begin
            logic [W-1:0] t;
            logic [W-1:0] s;
            bit           l;
            t = W'($urandom);
            s = W'($urandom);
            l = 1'($urandom_range(0, 1));
            wait_idle(d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(d, t, s, l);
            if ($urandom_range(0, 1) == 1) begin
               repeat ($urandom_range(1, 8)) @(negedge clk);
               drv_start[d] = 1'b1;
               drv_tx[d]    = W'($urandom);
               @(negedge clk);
               drv_start[d] = 1'b0;
            end
            wait_drain();
         end
      end

      repeat (40) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/spi_master.md
# spi_master

- Initiator end of the team's SPI link. Drives `sclk`, `ss` and `mosi`, and samples `miso` from the SPI slave on the far side.
- Each `start` pulse launches one full-duplex, MSB-first, mode-0 (CPOL=0, CPHA=0) transfer of `DATA_WIDTH` bits.
- `sclk` is derived from the system clock by a fixed divider.
- Sits on the host/FPGA side, between a command sequencer (`start`/`tx_data`/`rx_data`/`done`) and the board GPIO pins.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: bits per transfer.
- `CLK_DIV`, default 4 (H): system-clock cycles per `sclk` half-period. Must be ≥ 1.

Ports:
- `clk`  in  1: system clock. Single clock domain; all state updates on its rising edge.
- `rst_L`  in  1: asynchronous, active-low reset.
- `start`  in  1: transfer request; sampled only while `busy`=0.
- `tx_data`  in  DATA_WIDTH: byte to send; latched when `start` is accepted.
- `rx_data`  out  DATA_WIDTH: last completed received word. Updated only at completion.
- `busy`  out  1: high from the edge accepting `start` through the last HOLD cycle.
- `done`  out  1: one-cycle pulse at completion.
- `sclk`  out  1: SPI clock; idles low.
- `ss`  out  1: slave select, active high, asserted for the whole transfer.
- `mosi`  out  1: serial data to the slave.
- `miso`  in  1: serial data from the slave.

## Operation

- FSM states:
  - IDLE: `ss`=0, `sclk`=0, `busy`=0.
    - On `start`=1, load `tx_data` into the tx shift register, clear the rx shift register and bit counter, and go to SETUP.
  - SETUP (H cycles): `ss`=1 and `mosi`=tx[MSB]. After H cycles, drive `sclk` high and go to XFER.
  - XFER: divider toggles `sclk` every H cycles.
    - On each 0→1 edge of `sclk`, shift the current `miso` into rx LSB (MSB first overall) and increment the bit counter.
    - On each 1→0 edge of `sclk`, shift tx left so `mosi` presents the next bit.
    - After the DATA_WIDTH-th falling edge, go to HOLD. `mosi` then holds tx shift LSB-fill (0).
  - HOLD (H cycles): `sclk`=0, `ss`=1. On exit:
    - deassert `ss`;
    - copy rx shift to `rx_data`;
    - pulse `done`;
    - drop `busy`;
    - return to IDLE.
- `start` while `busy`=1 is ignored. Changes to `tx_data` after acceptance are ignored.
- `start`=1 in the same cycle `done`=1 is accepted (the FSM is already in IDLE). `ss` is then low for exactly one cycle between transfers.
- Divider counter width is $clog2(CLK_DIV). Bit counter width is $clog2(DATA_WIDTH+1). No wrap beyond DATA_WIDTH.
- Reset (async, any state): all of the following take effect immediately and the FSM goes to IDLE.
  - `sclk`=0, `ss`=0, `mosi`=0
  - `busy`=0, `done`=0
  - `rx_data`=0
  - shift registers and counters cleared
- A transfer interrupted by reset is abandoned. `rx_data` is not partially updated beyond the reset clear.

## Timing

- Edge 0 is the clk edge at which `start`=1 is sampled in IDLE.
- Edge 1: `ss`→1, `busy`→1, `mosi`=tx_data[DATA_WIDTH-1].
- k-th `sclk` rise: edge 1+(2k−1)·H. `miso` is sampled at this edge.
- k-th `sclk` fall: edge 1+2k·H. `mosi` updates to bit DATA_WIDTH−1−k at this edge.
- Completion at edge 1+(2·DATA_WIDTH+1)·H: `ss`→0, `busy`→0, `done`→1, `rx_data` valid.
  - `done` returns to 0 on the next edge.
  - For defaults this is edge 69.
- `mosi` is stable for at least H cycles before and after every rising `sclk` edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset: hold `rst_L`=0, toggle `clk`. Required: `sclk`=`ss`=`mosi`=`busy`=`done`=0 and `rx_data`=0x00. Assert `rst_L`=0 asynchronously mid-cycle and check outputs clear before the next edge.
- Single transfer, defaults: `tx_data`=0xA5, slave model shifts out 0x3C on `sclk` falls. Required:
  - `mosi` sampled at the 8 rises reads 1,0,1,0,0,1,0,1;
  - `done` pulses at edge 69;
  - `rx_data`=0x3C;
  - `ss` is high on edges 1–68.
- Ignore while busy: a second `start` with `tx_data`=0xFF at edge 20. Required: still 0xA5 on `mosi`, one `done` only, no restart.
- Back-to-back: `tx_data`=0x81 then 0x7E, with the second `start` held high in the `done` cycle. Required:
  - `ss` low for exactly 1 cycle between transfers;
  - loopback (`miso`=`mosi`) yields `rx_data`=0x81 then 0x7E.
- Reset mid-transfer: drop `rst_L` after the 4th `sclk` rise. Required:
  - immediate idle outputs;
  - a subsequent 0xC3 loopback transfer returns 0xC3 with nominal timing.
- `CLK_DIV`=1, `DATA_WIDTH`=8: `tx_data`=0x5A loopback. Required: `sclk` toggles every cycle, `done` at edge 18, `rx_data`=0x5A.
